// File: rtl/pwm_mixer_array.sv
// Multi-channel quadrature-encoder level mixer driving edge-aligned PWM outputs.
// Each channel debounces its encoder, adjusts a level per detent, and PWMs it via a shadowed duty.
module pwm_mixer_array #(
    parameter int CHANNELS     = 3,
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_LEN = 4,
    parameter int STEP         = 1,
    parameter int SATURATE     = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    input  logic                      load_valid,
    input  logic [2:0]                load_ch,
    input  logic [WIDTH-1:0]          load_value,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic [CHANNELS*WIDTH-1:0] level,
    output logic                      period_start
);

    localparam int             NB      = 2 * CHANNELS;
    localparam logic [WIDTH:0] STEP_W  = (WIDTH + 1)'(STEP);
    localparam bit             SAT_EN  = (SATURATE != 0);
    localparam logic [7:0]     DB_LAST = 8'(DEBOUNCE_LEN - 1);

    // Bits [CHANNELS-1:0] carry phase A, the upper half phase B.
    logic [NB-1:0]                     sync1_r;
    logic [NB-1:0]                     sync2_r;
    logic [NB-1:0]                     db_r;
    logic [7:0]                        db_cnt_r [NB];
    logic [1:0]                        vld_r;
    logic [CHANNELS-1:0]               armed_r;
    logic [CHANNELS-1:0]               db_a_d_r;
    logic [CHANNELS-1:0]               rise_s;
    logic [CHANNELS-1:0][WIDTH-1:0]    level_r;
    logic [CHANNELS-1:0][WIDTH-1:0]    level_nxt_s;
    logic [CHANNELS-1:0][WIDTH-1:0]    duty_r;
    logic [WIDTH-1:0]                  cnt_r;

    function automatic logic [WIDTH-1:0] step_level(input logic [WIDTH-1:0] cur, input logic down);
        logic [WIDTH:0] up_v;
        logic [WIDTH:0] dn_v;
        up_v = {1'b0, cur} + STEP_W;
        dn_v = {1'b0, cur} - STEP_W;
        if (down) begin
            if (SAT_EN && dn_v[WIDTH]) step_level = {WIDTH{1'b0}};
            else                       step_level = dn_v[WIDTH-1:0];
        end else begin
            if (SAT_EN && up_v[WIDTH]) step_level = {WIDTH{1'b1}};
            else                       step_level = up_v[WIDTH-1:0];
        end
    endfunction

    // Two-flop synchroniser for every raw encoder phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
        end else begin
            sync1_r <= {enc_b, enc_a};
            sync2_r <= sync1_r;
        end
    end

    // Debounce, arming and A edge history; a channel arms only once a real low A sample is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_r     <= {NB{1'b0}};
            vld_r    <= 2'b00;
            armed_r  <= {CHANNELS{1'b0}};
            db_a_d_r <= {CHANNELS{1'b0}};
            for (int j = 0; j < NB; j++) db_cnt_r[j] <= 8'd0;
        end else begin
            vld_r    <= {vld_r[0], 1'b1};
            armed_r  <= armed_r | ({CHANNELS{vld_r[1]}} & ~sync2_r[CHANNELS-1:0]);
            db_a_d_r <= db_r[CHANNELS-1:0];
            for (int j = 0; j < NB; j++) begin
                if (sync2_r[j] == db_r[j]) begin
                    db_cnt_r[j] <= 8'd0;
                end else if (db_cnt_r[j] == DB_LAST) begin
                    db_r[j]     <= sync2_r[j];
                    db_cnt_r[j] <= 8'd0;
                end else begin
                    db_cnt_r[j] <= db_cnt_r[j] + 8'd1;
                end
            end
        end
    end

    // Detent strobe: debounced A rising on an armed channel.
    always_comb begin
        rise_s = db_r[CHANNELS-1:0] & ~db_a_d_r & armed_r;
    end

    // Next level: a host load wins over a same-cycle detent, which is then lost.
    always_comb begin
        level_nxt_s = level_r;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load_valid && (load_ch == 3'(i))) begin
                level_nxt_s[i] = load_value;
            end else if (rise_s[i]) begin
                level_nxt_s[i] = step_level(level_r[i], db_r[CHANNELS+i]);
            end else begin
                level_nxt_s[i] = level_r[i];
            end
        end
    end

    // Working level registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_r <= {(CHANNELS*WIDTH){1'b0}};
        else          level_r <= level_nxt_s;
    end

    // Shared counter, period-boundary duty shadowing and registered PWM outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r        <= {WIDTH{1'b0}};
            duty_r       <= {(CHANNELS*WIDTH){1'b0}};
            pwm_out      <= {CHANNELS{1'b0}};
            period_start <= 1'b0;
        end else begin
            cnt_r        <= cnt_r + WIDTH'(1);
            period_start <= (cnt_r == {WIDTH{1'b0}});
            for (int i = 0; i < CHANNELS; i++) pwm_out[i] <= (cnt_r < duty_r[i]);
            if (cnt_r == {WIDTH{1'b1}}) duty_r <= level_r;
            else                        duty_r <= duty_r;
        end
    end

    assign level = level_r;

endmodule

// File: tb/tb_pwm_mixer_array.sv
// Scoreboard bench for pwm_mixer_array: a saturating and a wrapping instance share stimulus,
// a behavioural model queues expected outputs per edge, and a negedge monitor compares them.
module tb_pwm_mixer_array;

    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  enc_a, enc_b;
    logic        load_valid;
    logic [2:0]  load_ch;
    logic [7:0]  load_value;
    logic [2:0]  pwm_s, pwm_w;
    logic [23:0] lvl_s, lvl_w;
    logic        ps_s, ps_w;

    int checks = 0;
    int errors = 0;

    pwm_mixer_array #(.CHANNELS(3), .WIDTH(8), .DEBOUNCE_LEN(DL), .STEP(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .pwm_out(pwm_s), .level(lvl_s), .period_start(ps_s));

    pwm_mixer_array #(.CHANNELS(3), .WIDTH(8), .DEBOUNCE_LEN(DL), .STEP(1), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .pwm_out(pwm_w), .level(lvl_w), .period_start(ps_w));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  pwm_s;
        logic [2:0]  pwm_w;
        logic [23:0] lvl_s;
        logic [23:0] lvl_w;
        logic        ps;
    } exp_t;

    exp_t sbq[$];

    // Reference model state; index j<3 is phase A of channel j, j>=3 phase B of channel j-3.
    int m_s1[6], m_s2[6], m_db[6];
    int m_hist[6][$];
    int m_dbp[3], m_arm[3], m_lvs[3], m_lvw[3], m_dus[3], m_duw[3];
    int m_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 6; j++) begin
            m_s1[j] = -1; m_s2[j] = -1; m_db[j] = 0; m_hist[j].delete();
        end
        for (int i = 0; i < 3; i++) begin
            m_dbp[i] = 0; m_arm[i] = 0; m_lvs[i] = 0; m_lvw[i] = 0; m_dus[i] = 0; m_duw[i] = 0;
        end
        m_k = 0;
    endtask

    // One rising edge of the model, using the inputs that were present at that edge.
    task automatic model_step(input logic [2:0] a, input logic [2:0] b, input logic lv,
                              input logic [2:0] lch, input logic [7:0] lval);
        exp_t e;
        int   ph, smp, all_opp;
        m_k++;
        ph   = (m_k - 1) % 256;
        e.ps = (ph == 0);
        for (int i = 0; i < 3; i++) begin
            e.pwm_s[i] = (ph < m_dus[i]);
            e.pwm_w[i] = (ph < m_duw[i]);
        end
        if (ph == 255) begin
            for (int i = 0; i < 3; i++) begin m_dus[i] = m_lvs[i]; m_duw[i] = m_lvw[i]; end
        end
        for (int i = 0; i < 3; i++) begin
            if (lv && (int'(lch) == i)) begin
                m_lvs[i] = int'(lval); m_lvw[i] = int'(lval);
            end else if (m_db[i] == 1 && m_dbp[i] == 0 && m_arm[i] == 1) begin
                if (m_db[3+i] == 1) begin
                    m_lvs[i] = (m_lvs[i] > 0) ? m_lvs[i] - 1 : 0;
                    m_lvw[i] = (m_lvw[i] + 255) % 256;
                end else begin
                    m_lvs[i] = (m_lvs[i] < 255) ? m_lvs[i] + 1 : 255;
                    m_lvw[i] = (m_lvw[i] + 1) % 256;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_dbp[i] = m_db[i];
            if (m_s2[i] == 0) m_arm[i] = 1;
        end
        for (int j = 0; j < 6; j++) begin
            smp = (m_s2[j] < 0) ? 0 : m_s2[j];
            m_hist[j].push_back(smp);
            if (m_hist[j].size() > DL) void'(m_hist[j].pop_front());
            if (m_hist[j].size() == DL) begin
                all_opp = 1;
                foreach (m_hist[j][q]) if (m_hist[j][q] == m_db[j]) all_opp = 0;
                if (all_opp == 1) m_db[j] = 1 - m_db[j];
            end
            m_s2[j] = m_s1[j];
            m_s1[j] = (j < 3) ? int'(a[j]) : int'(b[j-3]);
        end
        for (int i = 0; i < 3; i++) begin
            e.lvl_s[i*8 +: 8] = m_lvs[i][7:0];
            e.lvl_w[i*8 +: 8] = m_lvw[i][7:0];
        end
        sbq.push_back(e);
    endtask

    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic lv,
                       input logic [2:0] lch, input logic [7:0] lval);
        enc_a = a; enc_b = b; load_valid = lv; load_ch = lch; load_value = lval;
        @(posedge clk);
        model_step(a, b, lv, lch, lval);
        #1;
    endtask

    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        repeat (n) cyc(a, b, 1'b0, 3'd0, 8'd0);
    endtask

    // Monitor: every post-reset edge presents a full output set to compare.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("level_sat", {8'd0, lvl_s}, {8'd0, e.lvl_s});
            chk("level_wrap", {8'd0, lvl_w}, {8'd0, e.lvl_w});
            chk("pwm_sat", {29'd0, pwm_s}, {29'd0, e.pwm_s});
            chk("pwm_wrap", {29'd0, pwm_w}, {29'd0, e.pwm_w});
            chk("period_start", {30'd0, ps_s, ps_w}, {30'd0, e.ps, e.ps});
        end
    end

    initial begin
        logic [2:0] ra, rb;
        logic [7:0] v;
        reset_n = 1'b0; enc_a = 3'd0; enc_b = 3'd0;
        load_valid = 1'b0; load_ch = 3'd0; load_value = 8'd0;
        model_reset();
        #12;
        chk("reset_level", {8'd0, lvl_s}, 32'd0);
        chk("reset_outs", {29'd0, pwm_s | pwm_w, ps_s | ps_w}, 32'd0);
        reset_n = 1'b1;

        hold(3'b000, 3'b000, 10);
        // single up-detent on ch0, then 3- and 4-cycle pulses
        hold(3'b001, 3'b000, 10); hold(3'b000, 3'b000, 8);
        hold(3'b001, 3'b000, 3);  hold(3'b000, 3'b000, 8);
        hold(3'b001, 3'b000, 4);  hold(3'b000, 3'b000, 8);
        // three down-detents from level 1
        cyc(3'b000, 3'b001, 1'b1, 3'd0, 8'd1);
        hold(3'b000, 3'b001, 6);
        repeat (3) begin hold(3'b001, 3'b001, 6); hold(3'b000, 3'b001, 6); end
        // upper boundary, then lower boundary
        cyc(3'b000, 3'b000, 1'b1, 3'd0, 8'd255);
        hold(3'b000, 3'b000, 6); hold(3'b001, 3'b000, 6); hold(3'b000, 3'b000, 6);
        cyc(3'b000, 3'b000, 1'b1, 3'd0, 8'd0);
        hold(3'b000, 3'b001, 6); hold(3'b001, 3'b001, 6); hold(3'b000, 3'b000, 6);
        // load colliding with a ch1 up-detent on the same edge
        hold(3'b000, 3'b000, 6);
        repeat (6) cyc(3'b010, 3'b000, 1'b0, 3'd0, 8'd0);
        cyc(3'b010, 3'b000, 1'b1, 3'd1, 8'h80);
        hold(3'b010, 3'b000, 4); hold(3'b000, 3'b000, 6);
        cyc(3'b000, 3'b000, 1'b1, 3'd5, 8'h33);
        // PWM duty behaviour
        cyc(3'b000, 3'b000, 1'b1, 3'd2, 8'd64);
        cyc(3'b000, 3'b000, 1'b1, 3'd1, 8'd0);
        hold(3'b000, 3'b000, 600);
        // asynchronous reset mid-period
        cyc(3'b000, 3'b000, 1'b1, 3'd0, 8'h40);
        hold(3'b000, 3'b000, 300);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_level", {8'd0, lvl_s | lvl_w}, 32'd0);
        chk("midreset_outs", {29'd0, pwm_s | pwm_w, ps_s | ps_w}, 32'd0);
        chk("midreset_queue", sbq.size(), 32'd0);
        model_reset();
        #2;
        reset_n = 1'b1;
        hold(3'b000, 3'b000, 20);
        // randomized encoder activity and host loads
        ra = 3'b000; rb = 3'b000;
        repeat (3000) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(5) == 0) ra[j] = ~ra[j];
                if ($urandom_range(7) == 0) rb[j] = ~rb[j];
            end
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(4))
                    0:       v = 8'd0;
                    1:       v = 8'd1;
                    2:       v = 8'd254;
                    3:       v = 8'd255;
                    default: v = 8'($urandom);
                endcase
                cyc(ra, rb, 1'b1, 3'($urandom_range(7)), v);
            end else begin
                cyc(ra, rb, 1'b0, 3'd0, 8'd0);
            end
        end
        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", sbq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
